fp_sub_seq: RTL and testbench

// - Multi-cycle IEEE-754 single-precision subtractor: result = a - b.
// - Partners the combinational FP adder in the decapre datapath; shares its 32-bit sign/exp/mantissa packing.
// - Exists for cases where an area-cheap shift-per-cycle datapath is preferred over a full barrel shifter.
// - Valid/ready handshake on both sides.

---
 rtl/fp_sub_seq.sv | 205 ++++++++++++++++++++
 tb/tb_fp_sub_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (a - b) with a shift-per-cycle datapath.
// Optional build macro FP_SUB_RNE_EN: round-to-nearest-even in ROUND; undefined truncates.
module fp_sub_seq #(
  parameter int MAX_SHIFT = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags,
  output logic [2:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never drops and the payload never changes until that transfer occurs.
  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_SPECIAL, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic        [31:0] a_q, a_d, b_q, b_d;
  logic               sx_q, sx_d, sy_q, sy_d, zero_q, zero_d;
  logic signed [9:0]  ex_q, ex_d;
  logic        [7:0]  gap_q, gap_d;
  logic        [26:0] mx_q, mx_d, my_q, my_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic        [31:0] out_data_q, out_data_d;
  logic        [2:0]  out_flags_q, out_flags_d;

  logic        [31:0] op_b, x_op, y_op, res, sp_res;
  logic               swap, special_in, round_up;
  logic        [27:0] sum;
  logic        [26:0] add_m;
  logic        [24:0] mant_r;
  logic signed [9:0]  e_r, add_e;
  logic        [22:0] frac;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  function automatic logic [2:0] classify(input logic [31:0] d);
    classify = {(&d[30:23]) & (|d[22:0]), (&d[30:23]) & ~(|d[22:0]), ~(|d[30:0])};
  endfunction

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sx_d        = sx_q;
    sy_d        = sy_q;
    zero_d      = zero_q;
    ex_d        = ex_q;
    gap_d       = gap_q;
    mx_d        = mx_q;
    my_d        = my_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;

    op_b       = {~in_b[31], in_b[30:0]};
    swap       = in_b[30:0] > in_a[30:0];
    x_op       = swap ? op_b : in_a;
    y_op       = swap ? in_a : op_b;
    special_in = (&in_a[30:23]) | ~(|in_a[30:23]) | (&in_b[30:23]) | ~(|in_b[30:23]);

    sum   = (sx_q ^ sy_q) ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
    add_m = sum[27] ? {sum[27:2], sum[1] | sum[0]} : sum[26:0];
    add_e = sum[27] ? ex_q + 10'sd1 : ex_q;

`ifdef FP_SUB_RNE_EN
    round_up = mx_q[2] & (mx_q[1] | mx_q[0] | mx_q[3]);
`else
    round_up = 1'b0;
`endif
    mant_r = {1'b0, mx_q[26:3]} + {24'd0, round_up};
    e_r    = mant_r[24] ? ex_q + 10'sd1 : ex_q;
    frac   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    if (zero_q)                res = 32'h0000_0000;
    else if (e_r >= 10'sd255)  res = {sx_q, 8'hff, 23'd0};
    else if (e_r <= 10'sd0)    res = {sx_q, 31'd0};
    else                       res = {sx_q, e_r[7:0], frac};

    // Operand b is stored already negated, so specials resolve as a + b_q.
    a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
    a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    a_zero = ~(|a_q[30:23]);
    b_zero = ~(|b_q[30:23]);
    if (a_nan | b_nan)         sp_res = 32'h7fc0_0000;
    else if (a_inf & b_inf)    sp_res = (a_q[31] != b_q[31]) ? 32'h7fc0_0000 : a_q;
    else if (a_inf)            sp_res = a_q;
    else if (b_inf)            sp_res = b_q;
    else if (a_zero & b_zero)  sp_res = {a_q[31] & b_q[31], 31'd0};
    else if (a_zero)           sp_res = b_q;
    else                       sp_res = a_q;

    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d        = in_a;
        b_d        = op_b;
        sx_d       = x_op[31];
        sy_d       = y_op[31];
        ex_d       = {2'b00, x_op[30:23]};
        gap_d      = x_op[30:23] - y_op[30:23];
        mx_d       = {1'b1, x_op[22:0], 3'b000};
        my_d       = {1'b1, y_op[22:0], 3'b000};
        zero_d     = 1'b0;
        in_ready_d = 1'b0;
        state_d    = special_in ? S_SPECIAL : S_ALIGN;
      end
      S_ALIGN: begin
        if (gap_q == 8'd0) begin
          state_d = S_ADD;
        end else if (gap_q > 8'(MAX_SHIFT)) begin
          my_d    = 27'd1;
          gap_d   = 8'd0;
          state_d = S_ADD;
        end else begin
          my_d  = {1'b0, my_q[26:2], my_q[1] | my_q[0]};
          gap_d = gap_q - 8'd1;
          if (gap_q == 8'd1) state_d = S_ADD;
        end
      end
      S_ADD: begin
        mx_d = add_m;
        ex_d = add_e;
        if (add_m == 27'd0) begin
          zero_d  = 1'b1;
          state_d = S_ROUND;
        end else begin
          state_d = add_m[26] ? S_ROUND : S_NORM;
        end
      end
      S_NORM: begin
        mx_d = {mx_q[25:0], 1'b0};
        ex_d = ex_q - 10'sd1;
        if (mx_q[25]) state_d = S_ROUND;
      end
      S_ROUND: begin
        out_data_d  = res;
        out_flags_d = classify(res);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_SPECIAL: begin
        out_data_d  = sp_res;
        out_flags_d = classify(sp_res);
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sx_q        <= 1'b0;
      sy_q        <= 1'b0;
      zero_q      <= 1'b0;
      ex_q        <= '0;
      gap_q       <= '0;
      mx_q        <= '0;
      my_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      zero_q      <= zero_d;
      ex_q        <= ex_d;
      gap_q       <= gap_d;
      mx_q        <= mx_d;
      my_q        <= my_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed vectors through a scoreboard queue plus handshake/reset checks.
module tb_fp_sub_seq;
  localparam int MAX_SHIFT = 26;
  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_data;
  logic [2:0]  out_flags, dbg_state;

  logic [34:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  fp_sub_seq #(.MAX_SHIFT(MAX_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flags_of(input logic [31:0] d);
    logic nan, inf, zero;
    nan  = (d[30:23] == 8'hff) && (d[22:0] != 23'd0);
    inf  = (d[30:23] == 8'hff) && (d[22:0] == 23'd0);
    zero = (d[30:0] == 31'd0);
    return {nan, inf, zero};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({flags_of(want), want});
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, output int lat);
    logic [34:0] e;
    int n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    lat = n;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_qsize"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, {29'd0, out_flags, out_data}, {29'd0, e});
    end
    out_ready = 1'b1;
    tick();
  endtask

  logic [31:0] va[NV], vb[NV], vr[NV];
  int          lat;
  logic [31:0] held;

  initial begin
    va[0]  = 32'h4000_0000; vb[0]  = 32'h3f00_0000; vr[0]  = 32'h3fc0_0000;
    va[1]  = 32'h4000_0000; vb[1]  = 32'h0000_0000; vr[1]  = 32'h4000_0000;
    va[2]  = 32'h4000_0000; vb[2]  = 32'h4000_0000; vr[2]  = 32'h0000_0000;
    va[3]  = 32'h3f00_0000; vb[3]  = 32'h4000_0000; vr[3]  = 32'hbfc0_0000;
    va[4]  = 32'h3f80_0000; vb[4]  = 32'h0080_0000;
    va[5]  = 32'h3fc0_0000; vb[5]  = 32'h3380_0000;
    va[6]  = 32'h7f80_0000; vb[6]  = 32'h7f80_0000; vr[6]  = 32'h7fc0_0000;
    va[7]  = 32'h7f7f_ffff; vb[7]  = 32'hff7f_ffff; vr[7]  = 32'h7f80_0000;
    va[8]  = 32'h3f80_0000; vb[8]  = 32'hbf80_0000; vr[8]  = 32'h4000_0000;
    va[9]  = 32'h4040_0000; vb[9]  = 32'h3f80_0000; vr[9]  = 32'h4000_0000;
    va[10] = 32'h0000_0000; vb[10] = 32'h0000_0000; vr[10] = 32'h0000_0000;
    va[11] = 32'h8000_0000; vb[11] = 32'h0000_0000; vr[11] = 32'h8000_0000;
    va[12] = 32'h7fc0_0001; vb[12] = 32'h3f80_0000; vr[12] = 32'h7fc0_0000;
    va[13] = 32'h7f80_0000; vb[13] = 32'h3f80_0000; vr[13] = 32'h7f80_0000;
    va[14] = 32'h3f80_0000; vb[14] = 32'h7f80_0000; vr[14] = 32'hff80_0000;
    va[15] = 32'h0000_0000; vb[15] = 32'h4000_0000; vr[15] = 32'hc000_0000;
    va[16] = 32'h0040_0000; vb[16] = 32'h3f80_0000; vr[16] = 32'hbf80_0000;
    va[17] = 32'h00c0_0000; vb[17] = 32'h0080_0000; vr[17] = 32'h0000_0000;
    va[18] = 32'hff80_0000; vb[18] = 32'h7f80_0000; vr[18] = 32'hff80_0000;
    va[19] = 32'h3f80_0000; vb[19] = 32'h3300_0000;
    va[20] = 32'hbf80_0000; vb[20] = 32'hbf80_0000; vr[20] = 32'h0000_0000;
    va[21] = 32'h4980_0000; vb[21] = 32'h3f80_0000; vr[21] = 32'h497f_fff0;
`ifdef FP_SUB_RNE_EN
    vr[4] = 32'h3f80_0000; vr[5] = 32'h3fc0_0000; vr[19] = 32'h3f80_0000;
`else
    vr[4] = 32'h3f7f_ffff; vr[5] = 32'h3fbf_ffff; vr[19] = 32'h3f7f_ffff;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], vr[i]);
      recv($sformatf("vec%0d", i), lat);
      check($sformatf("vec%0d_lat_max", i), 64'(lat <= MAX_SHIFT + 30), 64'd1);
      if (i == 2) check("lat_min_equal_exp", 64'(lat), 64'd3);
    end

    // Back-pressure: result must stay put and new operands must be refused.
    out_ready = 1'b0;
    send(32'h4000_0000, 32'h3f00_0000, 32'h3fc0_0000);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    held = out_data;
    check("bp_first_data", 64'(held), 64'h3fc0_0000);
    in_a = 32'h3f80_0000; in_b = 32'hbf80_0000; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_data_stable", 64'(out_data), 64'(held));
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    recv("bp_result", lat);
    repeat (3) tick();
    check("bp_no_extra_result", 64'(out_valid), 64'd0);

    // Reset while shifting a 20-bit exponent gap.
    send(32'h4980_0000, 32'h3f80_0000, 32'h497f_fff0);
    tick(); tick();
    check("mid_align_state", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_state", 64'(dbg_state), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    send(32'h3f00_0000, 32'h4000_0000, 32'hbfc0_0000);
    recv("post_rst", lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
